// File: rtl/alu_rs_pkg.sv
// rtl/alu_rs_pkg.sv - shared ROB/op-width constants, ALU op encodings and RS entry type
package alu_rs_pkg;

  localparam int ROB_SIZE_WIDTH       = 4;
  localparam int TAG_W                = ROB_SIZE_WIDTH + 1;
  localparam int CALC_OP_L1_NUM_WIDTH = 4;
  localparam int RS_DEFAULT_SIZE      = 8;
  localparam int RS_DEFAULT_WIDTH     = 3;

  localparam logic [CALC_OP_L1_NUM_WIDTH-1:0] CALC_ADD  = 4'd0;
  localparam logic [CALC_OP_L1_NUM_WIDTH-1:0] CALC_SLL  = 4'd1;
  localparam logic [CALC_OP_L1_NUM_WIDTH-1:0] CALC_SLT  = 4'd2;
  localparam logic [CALC_OP_L1_NUM_WIDTH-1:0] CALC_SLTU = 4'd3;
  localparam logic [CALC_OP_L1_NUM_WIDTH-1:0] CALC_XOR  = 4'd4;
  localparam logic [CALC_OP_L1_NUM_WIDTH-1:0] CALC_SRL  = 4'd5;
  localparam logic [CALC_OP_L1_NUM_WIDTH-1:0] CALC_OR   = 4'd6;
  localparam logic [CALC_OP_L1_NUM_WIDTH-1:0] CALC_AND  = 4'd7;
  // op_L2 selects the alternate flavour (SUB for ADD, SRA for SRL)
  localparam logic CALC_L2_NORMAL = 1'b0;
  localparam logic CALC_L2_ALT    = 1'b1;

  typedef struct packed {
    logic                            busy;
    logic [CALC_OP_L1_NUM_WIDTH-1:0] op_l1;
    logic                            op_l2;
    logic [31:0]                     vj;
    logic [31:0]                     vk;
    logic                            qj_valid;
    logic [TAG_W-1:0]                qj;
    logic                            qk_valid;
    logic [TAG_W-1:0]                qk;
    logic [TAG_W-1:0]                dest;
  } rs_entry_t;

  function automatic logic tag_hit(input logic bcast_valid,
                                   input logic [TAG_W-1:0] bcast_tag,
                                   input logic [TAG_W-1:0] wait_tag);
    return bcast_valid && (bcast_tag == wait_tag);
  endfunction

endpackage

// File: rtl/alu_rs_pick.sv
// rtl/alu_rs_pick.sv - priority encoder returning the lowest set request bit and a found flag
module alu_rs_pick #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         found
);

  // Scan from the top so the lowest set bit is the last assignment.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// rtl/alu_rs.sv - ALU reservation station: dispatch with CDB bypass, wakeup, in-index-order issue
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE       = RS_DEFAULT_SIZE,
  parameter int RS_SIZE_WIDTH = RS_DEFAULT_WIDTH
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            rdy_in,
  input  logic                            need_flush_in,
  input  logic                            inst_valid_in,
  input  logic [CALC_OP_L1_NUM_WIDTH-1:0] op_L1_in,
  input  logic                            op_L2_in,
  input  logic [31:0]                     vj_in,
  input  logic [31:0]                     vk_in,
  input  logic                            qj_valid_in,
  input  logic                            qk_valid_in,
  input  logic [TAG_W-1:0]                qj_in,
  input  logic [TAG_W-1:0]                qk_in,
  input  logic [TAG_W-1:0]                dest_in,
  input  logic                            alu_ready_in,
  input  logic                            lsb_ready_in,
  input  logic [TAG_W-1:0]                alu_dependency_in,
  input  logic [TAG_W-1:0]                lsb_dependency_in,
  input  logic [31:0]                     alu_value_in,
  input  logic [31:0]                     lsb_value_in,
  output logic                            full_out,
  output logic                            alu_valid_out,
  output logic [31:0]                     alu_opr1_out,
  output logic [31:0]                     alu_opr2_out,
  output logic [TAG_W-1:0]                alu_dependency_out,
  output logic [CALC_OP_L1_NUM_WIDTH-1:0] alu_op_L1_out,
  output logic                            alu_op_L2_out
);

  rs_entry_t               ent [RS_SIZE];
  rs_entry_t               new_ent;
  logic [RS_SIZE-1:0]      busy_vec;
  logic [RS_SIZE-1:0]      ready_vec;
  logic [RS_SIZE_WIDTH-1:0] free_idx;
  logic [RS_SIZE_WIDTH-1:0] issue_idx;
  logic                    free_found;
  logic                    issue_found;

  always_comb begin
    busy_vec  = '0;
    ready_vec = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      busy_vec[i]  = ent[i].busy;
      ready_vec[i] = ent[i].busy && !ent[i].qj_valid && !ent[i].qk_valid;
    end
  end

  assign full_out = &busy_vec;

  alu_rs_pick #(.N(RS_SIZE), .W(RS_SIZE_WIDTH)) u_free_pick (
    .req   (~busy_vec),
    .idx   (free_idx),
    .found (free_found)
  );

  alu_rs_pick #(.N(RS_SIZE), .W(RS_SIZE_WIDTH)) u_issue_pick (
    .req   (ready_vec),
    .idx   (issue_idx),
    .found (issue_found)
  );

  // Incoming entry, with operands resolved by a same-cycle broadcast (ALU port first).
  always_comb begin
    new_ent          = '0;
    new_ent.busy     = 1'b1;
    new_ent.op_l1    = op_L1_in;
    new_ent.op_l2    = op_L2_in;
    new_ent.dest     = dest_in;
    new_ent.vj       = vj_in;
    new_ent.qj       = qj_in;
    new_ent.qj_valid = qj_valid_in;
    new_ent.vk       = vk_in;
    new_ent.qk       = qk_in;
    new_ent.qk_valid = qk_valid_in;
    if (qj_valid_in && tag_hit(alu_ready_in, alu_dependency_in, qj_in)) begin
      new_ent.vj       = alu_value_in;
      new_ent.qj_valid = 1'b0;
    end else if (qj_valid_in && tag_hit(lsb_ready_in, lsb_dependency_in, qj_in)) begin
      new_ent.vj       = lsb_value_in;
      new_ent.qj_valid = 1'b0;
    end
    if (qk_valid_in && tag_hit(alu_ready_in, alu_dependency_in, qk_in)) begin
      new_ent.vk       = alu_value_in;
      new_ent.qk_valid = 1'b0;
    end else if (qk_valid_in && tag_hit(lsb_ready_in, lsb_dependency_in, qk_in)) begin
      new_ent.vk       = lsb_value_in;
      new_ent.qk_valid = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) ent[i].busy <= 1'b0;
      alu_valid_out <= 1'b0;
    end else if (rdy_in) begin
      if (need_flush_in) begin
        for (int i = 0; i < RS_SIZE; i++) ent[i].busy <= 1'b0;
        alu_valid_out <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (ent[i].busy) begin
            if (ent[i].qj_valid && tag_hit(alu_ready_in, alu_dependency_in, ent[i].qj)) begin
              ent[i].vj       <= alu_value_in;
              ent[i].qj_valid <= 1'b0;
            end else if (ent[i].qj_valid && tag_hit(lsb_ready_in, lsb_dependency_in, ent[i].qj)) begin
              ent[i].vj       <= lsb_value_in;
              ent[i].qj_valid <= 1'b0;
            end
            if (ent[i].qk_valid && tag_hit(alu_ready_in, alu_dependency_in, ent[i].qk)) begin
              ent[i].vk       <= alu_value_in;
              ent[i].qk_valid <= 1'b0;
            end else if (ent[i].qk_valid && tag_hit(lsb_ready_in, lsb_dependency_in, ent[i].qk)) begin
              ent[i].vk       <= lsb_value_in;
              ent[i].qk_valid <= 1'b0;
            end
          end
        end
        alu_valid_out <= issue_found;
        if (issue_found) begin
          alu_opr1_out            <= ent[issue_idx].vj;
          alu_opr2_out            <= ent[issue_idx].vk;
          alu_dependency_out      <= ent[issue_idx].dest;
          alu_op_L1_out           <= ent[issue_idx].op_l1;
          alu_op_L2_out           <= ent[issue_idx].op_l2;
          ent[issue_idx].busy     <= 1'b0;
        end
        // The free slot is never the issuing one, so both proceed together.
        if (inst_valid_in && free_found) ent[free_idx] <= new_ent;
      end
    end
  end

endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 SHALL have parameter RS_SIZE, default 8, number of reservation entries (power of two).
REQ-002 SHALL have parameter RS_SIZE_WIDTH, default 3, log2(RS_SIZE); ROB tag width is `ROB_SIZE_WIDTH+1 bits (TW); op widths are `CALC_OP_L1_NUM_WIDTH (4) and 1.
REQ-003 SHALL have ports (clock and reset first):
 clk_in  in  1  clock; one clock, all state updates on its rising edge
 rst_in  in  1  synchronous, active-high reset
 rdy_in  in  1  global enable; low = hold all state and outputs
 need_flush_in  in  1  misprediction flush
 inst_valid_in  in  1  dispatch request
 op_L1_in / op_L2_in  in  4/1  ALU op codes
 vj_in, vk_in  in  32  operand values
 qj_valid_in, qk_valid_in  in  1  1 = operand still pending
 qj_in, qk_in  in  TW  ROB tag producing pending operand
 dest_in  in  TW  ROB tag of this instruction
 alu_ready_in, lsb_ready_in  in  1  CDB broadcast valid (ALU, load/store buffer)
 alu_dependency_in, lsb_dependency_in  in  TW  broadcast ROB tag
 alu_value_in, lsb_value_in  in  32  broadcast value
 full_out  out  1  all entries busy (combinational from busy bits)
 alu_valid_out  out  1  issue strobe to ALU
 alu_opr1_out, alu_opr2_out  out  32  issued operands
 alu_dependency_out  out  TW  issued ROB tag
 alu_op_L1_out / alu_op_L2_out  out  4/1  issued op codes

Function
REQ-004 Entry state SHALL be: busy, op_L1, op_L2, vj, vk, qj_valid, qj, qk_valid, qk, dest.
REQ-005 Dispatch (inst_valid_in=1, full_out=0, no flush) SHALL write the lowest-index non-busy entry and set busy at the next edge.
REQ-006 Dispatch while full_out=1 SHALL be ignored; upstream must not do so.
REQ-007 Dispatch bypass: a pending operand whose tag equals a same-cycle valid CDB tag SHALL be stored resolved with the broadcast value.
REQ-008 Wakeup: each busy entry with qX_valid=1 and qX equal to a valid CDB tag SHALL capture the value and clear qX_valid at the next edge; ALU port wins if both ports match (not expected).
REQ-009 An entry SHALL be eligible when busy and both qj_valid=0 and qk_valid=0 in registered state; operands woken this cycle become eligible next cycle.
REQ-010 Each cycle the lowest-index eligible entry SHALL be issued: outputs registered at the edge, alu_valid_out=1 for exactly one cycle, entry busy cleared at the same edge.
REQ-011 No eligible entry SHALL give alu_valid_out=0; data outputs then hold previous values.
REQ-012 Issue latency: dispatch with both operands ready at edge N -> entry eligible after N -> alu_valid_out=1 after edge N+1.
REQ-013 Freed entry SHALL be reusable by a dispatch in the following cycle; dispatch and issue in the same cycle SHALL both proceed.
REQ-014 need_flush_in=1 (rdy_in=1) SHALL clear all busy bits and alu_valid_out at the next edge; dispatch, wakeup and issue that cycle are discarded.
REQ-015 rdy_in=0 SHALL freeze all entries and outputs, including alu_valid_out.
REQ-016 full_out SHALL equal AND of all busy bits.

Reset
REQ-017 rst_in=1 at an edge SHALL clear all busy bits and alu_valid_out to 0, regardless of rdy_in; data registers need no reset.
REQ-018 Reset mid-operation SHALL discard all entries; full_out=0 the cycle after.

Structure
REQ-019 ROB_SIZE_WIDTH, CALC_OP_L1_NUM_WIDTH, ALU op encodings SHALL come from the shared const_param header; RS_SIZE constants also belong there.
REQ-020 One sub-module alu_rs_pick (priority encoder: lowest set bit + found flag) SHALL be instantiated twice: free-slot and eligible-entry selection.

Verification
REQ-021 Reset, then dispatch ADD vj=5 vk=7 dest=3, both ready -> two edges later alu_valid_out=1, opr1=5, opr2=7, dependency=3, one cycle only.
REQ-022 Dispatch SUB qj_valid=1 qj=2, vk=1; later alu_ready_in with tag 2 value 10 -> issue next-next cycle with opr1=10, opr2=1.
REQ-023 Dispatch with qk=4 pending while lsb_ready_in broadcasts tag 4 value 0xFFFF_FFFF same cycle -> entry stored ready, issues with opr2=0xFFFF_FFFF.
REQ-024 Fill 8 entries all pending -> full_out=1, 9th dispatch ignored; wake tag of entry 0 -> entry 0 issues, full_out=0 next cycle.
REQ-025 Three ready entries plus need_flush_in pulse -> no further alu_valid_out, full_out=0; rdy_in=0 for 3 cycles mid-stream -> outputs frozen, issue order unchanged.
